// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// On-chip exerciser for a 4-input / 2-output combinational block. A run walks
// all 16 input vectors {a,b,c,d} in ascending order, holds each one for DWELL
// cycles, samples f_in/g_in in one SAMPLE cycle per vector, compares them with
// the EXP_F/EXP_G truth tables and reports the captured tables, a mismatch
// count and a pass flag.
//
// Parameters:
//   DWELL  cycles each vector is held before it is sampled (1..255)
//   EXP_F  expected f table, bit i = f for vector i
//   EXP_G  expected g table, bit i = g for vector i
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, abort    begin a run (IDLE only) / terminate a run in progress
//   a, b, c, d      stimulus, {a,b,c,d} == vec_idx (a is the MSB)
//   f_in, g_in      outputs of the block under test
//   busy, done      busy in APPLY/SAMPLE, one-cycle done at end of a full run
//   vec_idx         current vector index
//   f_cap, g_cap    captured tables
//   err_cnt         mismatching vectors (0..16)
//   pass            completed run with no mismatch
//
// Optional build macro SEQ_STOP_ON_ERR_EN: the first mismatching vector ends
// the run immediately and its index is left on vec_idx until the next start.
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int          DWELL = 4,
    parameter logic [15:0] EXP_F = 16'h0000,
    parameter logic [15:0] EXP_G = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    input  logic        g_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  vec_idx,
    output logic [15:0] f_cap,
    output logic [15:0] g_cap,
    output logic [4:0]  err_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t      state_q,   state_d;
    logic [3:0]  vec_q,     vec_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [15:0] f_cap_q,   f_cap_d;
    logic [15:0] g_cap_q,   g_cap_d;
    logic [4:0]  err_q,     err_d;
    logic        pass_q,    pass_d;
    logic        mismatch_s;

    // Compare the sampled outputs of the block under test against the tables.
    always_comb begin
        mismatch_s = (f_in != EXP_F[vec_q]) || (g_in != EXP_G[vec_q]);
    end

    // Next-state and datapath updates for the run controller.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        f_cap_d = f_cap_q;
        g_cap_d = g_cap_q;
        err_d   = err_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                // abort has no meaning here, so start wins even with abort high
                if (start) begin
                    f_cap_d = 16'h0000;
                    g_cap_d = 16'h0000;
                    err_d   = 5'd0;
                    pass_d  = 1'b0;
                    vec_d   = 4'd0;
                    cnt_d   = 8'd0;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_APPLY: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    vec_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        state_d = ST_APPLY;
                    end
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    // leave with partial results, nothing captured this cycle
                    pass_d  = 1'b0;
                    vec_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    f_cap_d[vec_q] = f_in;
                    g_cap_d[vec_q] = g_in;
                    // at most 16 increments per run, the guard keeps it from wrapping
                    if (mismatch_s && (err_q != 5'd16)) begin
                        err_d = err_q + 5'd1;
                    end else begin
                        err_d = err_q;
                    end
`ifdef SEQ_STOP_ON_ERR_EN
                    if (mismatch_s || (vec_q == 4'd15)) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 4'd1;
                        cnt_d   = 8'd0;
                        state_d = ST_APPLY;
                    end
`else
                    if (vec_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 4'd1;
                        cnt_d   = 8'd0;
                        state_d = ST_APPLY;
                    end
`endif
                end
            end

            ST_DONE: begin
                pass_d  = (err_q == 5'd0);
`ifdef SEQ_STOP_ON_ERR_EN
                // keep the stopping index visible (15 on a clean run)
                vec_d   = vec_q;
`else
                vec_d   = 4'd0;
`endif
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 8'd0;
            f_cap_q <= 16'h0000;
            g_cap_q <= 16'h0000;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            f_cap_q <= f_cap_d;
            g_cap_q <= g_cap_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs are either register copies or decodes of the registered state.
    always_comb begin
        busy    = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
        done    = (state_q == ST_DONE);
        vec_idx = vec_q;
        a       = vec_q[3];
        b       = vec_q[2];
        c       = vec_q[1];
        d       = vec_q[0];
        f_cap   = f_cap_q;
        g_cap   = g_cap_q;
        err_cnt = err_q;
        pass    = pass_q;
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    localparam int          DW   = 4;
    localparam logic [15:0] EXPF = 16'h6996;
    localparam logic [15:0] EXPG = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        a, b, c, d;
    logic        f_in, g_in;
    logic        busy, done, pass;
    logic [3:0]  vec_idx;
    logic [15:0] f_cap, g_cap;
    logic [4:0]  err_cnt;

    // fault masks: bit i flips the model output for vector i
    logic [15:0] flip_f = 16'h0000;
    logic [15:0] flip_g = 16'h0000;

    int n_chk  = 0;
    int n_fail = 0;

    truth_table_sequencer #(.DWELL(DW), .EXP_F(EXPF), .EXP_G(EXPG)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .d(d), .f_in(f_in), .g_in(g_in),
        .busy(busy), .done(done), .vec_idx(vec_idx),
        .f_cap(f_cap), .g_cap(g_cap), .err_cnt(err_cnt), .pass(pass)
    );

    always #5 clk = ~clk;

    // block under test: f = parity of the inputs, g = AND of the inputs
    always_comb begin
        f_in = (a ^ b ^ c ^ d) ^ flip_f[{a, b, c, d}];
        g_in = (a & b & c & d) ^ flip_g[{a, b, c, d}];
    end

    function automatic logic ref_f(input int i);
        return logic'($countones(4'(i)) % 2);
    endfunction

    function automatic logic ref_g(input int i);
        return logic'(i == 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_vec"}, 32'(vec_idx), 32'd0);
        chk({tag, "_fcap"}, 32'(f_cap), 32'd0);
        chk({tag, "_gcap"}, 32'(g_cap), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    // One full run from an IDLE start; start is pulsed randomly while busy.
    task automatic run(input logic [15:0] ff, input logic [15:0] fg, input logic abort_at_start);
        int m, last, jd, err;
        logic [15:0] ef, eg;
        logic [3:0]  ev_end;
        flip_f = ff;
        flip_g = fg;
        m = 16;
        for (int i = 15; i >= 0; i--) if (ff[i] | fg[i]) m = i;
        last = 15;
`ifdef SEQ_STOP_ON_ERR_EN
        if (m < 16) last = m;
        ev_end = (m < 16) ? 4'(m) : 4'd15;
`else
        ev_end = 4'd0;
`endif
        ef = 16'h0000;
        eg = 16'h0000;
        err = 0;
        for (int i = 0; i <= last; i++) begin
            ef[i] = ref_f(i) ^ ff[i];
            eg[i] = ref_g(i) ^ fg[i];
            if (ef[i] != EXPF[i] || eg[i] != EXPG[i]) err++;
        end
        jd = 1 + (last + 1) * (DW + 1);

        start = 1'b1;
        abort = abort_at_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int j = 1; j < jd; j++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done_early", 32'(done), 32'd0);
            chk("run_vec", 32'(vec_idx), 32'((j - 1) / (DW + 1)));
            chk("run_abcd", 32'({a, b, c, d}), 32'((j - 1) / (DW + 1)));
            start = 1'($urandom_range(0, 1));
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        chk("end_done", 32'(done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_fcap", 32'(f_cap), 32'(ef));
        chk("end_gcap", 32'(g_cap), 32'(eg));
        chk("end_err", 32'(err_cnt), 32'(err));
        chk("end_pass", 32'(pass), 32'(err == 0));
        chk("end_vec", 32'(vec_idx), 32'(ev_end));
        tick();
        chk("idle_hold_busy", 32'(busy), 32'd0);
        chk("idle_hold_vec", 32'(vec_idx), 32'(ev_end));
        chk("idle_hold_err", 32'(err_cnt), 32'(err));
    endtask

    initial begin
        // reset
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        // clean run, then g stuck at 0, then f wrong only at vector 3
        run(16'h0000, 16'h0000, 1'b0);
        run(16'h0000, 16'h8000, 1'b0);
        run(16'h0008, 16'h0000, 1'b0);

        // abort during the SAMPLE cycle of vector 3 (cycle T+20)
        flip_f = 16'h0000;
        flip_g = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        chk("pre_abort_vec", 32'(vec_idx), 32'd3);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_vec", 32'(vec_idx), 32'd0);
        chk("abort_fcap", 32'(f_cap), 32'h0006);
        chk("abort_err", 32'(err_cnt), 32'd0);
        for (int j = 0; j < 5; j++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end

        // start together with abort in IDLE still starts a normal run
        run(16'h0000, 16'h0000, 1'b1);

        // reset in the middle of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 30; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");

        // randomised fault patterns (sparse, sometimes none)
        for (int r = 0; r < 6; r++) begin
            logic [15:0] rf, rg;
            rf = 16'($urandom & $urandom & $urandom);
            rg = 16'($urandom & $urandom & $urandom & $urandom);
            if (r == 0) begin
                rf = 16'h0000;
                rg = 16'h0000;
            end
            run(rf, rg, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
